// File: rtl/micro_pkg.sv
// Shared types and BCD constants for the microwave cook controller.
package micro_pkg;

    // Controller states; encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] ZERO_TIME      = 16'h0000;
    localparam logic [15:0] MAX_TIME       = 16'h9959;
    // Seconds digits reload to 5/9 when a borrow passes through them.
    localparam logic [3:0]  SEC_TENS_WRAP  = 4'h5;
    localparam logic [3:0]  SEC_UNITS_WRAP = 4'h9;

endpackage

// File: rtl/cook_sequencer_if.sv
// Operator-panel bundle between the keypad/door side and the cook controller.
interface cook_sequencer_if;

    logic        start;
    logic        stop;
    logic        clear;
    logic        door_closed;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        magnetron_en;
    logic [15:0] time_bcd;
    logic        busy;
    logic        done_beep;
    logic [2:0]  state_o;

    modport master (
        output start, stop, clear, door_closed, digit_valid, digit,
        input  magnetron_en, time_bcd, busy, done_beep, state_o
    );

    modport slave (
        input  start, stop, clear, door_closed, digit_valid, digit,
        output magnetron_en, time_bcd, busy, done_beep, state_o
    );

endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational BCD MM:SS minus one second. Seconds borrow from minutes,
// 00 seconds becomes 59. Result for 00:00 is meaningless; never applied there.
module bcd_mmss_dec
    import micro_pkg::*;
(
    input  logic [15:0] time_in,
    output logic [15:0] time_out
);

    // Ripple the borrow from seconds units up through the minute digits.
    always_comb begin
        time_out = time_in;
        if (time_in[3:0] != 4'd0) begin
            time_out[3:0] = time_in[3:0] - 4'd1;
        end else begin
            time_out[3:0] = SEC_UNITS_WRAP;
            if (time_in[7:4] != 4'd0) begin
                time_out[7:4] = time_in[7:4] - 4'd1;
            end else begin
                time_out[7:4] = SEC_TENS_WRAP;
                if (time_in[11:8] != 4'd0) begin
                    time_out[11:8] = time_in[11:8] - 4'd1;
                end else begin
                    time_out[11:8]  = 4'h9;
                    time_out[15:12] = time_in[15:12] - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad MM:SS entry, one-second countdown,
// door-interlocked magnetron drive and a timed completion beep.
module cook_sequencer
    import micro_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BEEP_CYCLES   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    cook_sequencer_if.slave  bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    // DONE lasts while the counter walks BEEP_CYCLES-1 down to 0.
    localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [15:0]   time_q, time_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [BW-1:0] beep_cnt, beep_nxt;
    logic [15:0]   time_dec;
    logic [15:0]   time_norm;
    logic          digit_ok;

    bcd_mmss_dec u_dec (
        .time_in  (time_q),
        .time_out (time_dec)
    );

    assign digit_ok = bus.digit_valid && (bus.digit <= 4'd9);

    // Fold entered seconds above 59 into the minutes; saturate at 99:59.
    always_comb begin
        time_norm = time_q;
        if (time_q[7:4] > SEC_TENS_WRAP) begin
            time_norm[7:4] = time_q[7:4] - 4'd6;
            if (time_q[11:8] == 4'd9) begin
                time_norm[11:8] = 4'd0;
                if (time_q[15:12] == 4'd9) begin
                    time_norm = MAX_TIME;
                end else begin
                    time_norm[15:12] = time_q[15:12] + 4'd1;
                end
            end else begin
                time_norm[11:8] = time_q[11:8] + 4'd1;
            end
        end
    end

    // Register state, time, prescaler and beep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            time_q   <= ZERO_TIME;
            presc    <= '0;
            beep_cnt <= '0;
        end else begin
            state    <= state_nxt;
            time_q   <= time_nxt;
            presc    <= presc_nxt;
            beep_cnt <= beep_nxt;
        end
    end

    // Next-state logic; clear > stop > door open > start > digit > tick.
    always_comb begin
        state_nxt = state;
        time_nxt  = time_q;
        presc_nxt = presc;
        beep_nxt  = beep_cnt;
        case (state)
            IDLE: begin
                time_nxt = ZERO_TIME;
                if (!bus.clear && !bus.stop && digit_ok) begin
                    time_nxt  = {time_q[11:0], bus.digit};
                    state_nxt = ENTRY;
                end
            end
            ENTRY: begin
                if (bus.clear || bus.stop) begin
                    time_nxt  = ZERO_TIME;
                    state_nxt = IDLE;
                end else if (bus.start && bus.door_closed && time_q != ZERO_TIME) begin
                    time_nxt  = time_norm;
                    presc_nxt = '0;
                    state_nxt = COOK;
                end else if (digit_ok && time_q[15:12] == 4'd0) begin
                    time_nxt = {time_q[11:0], bus.digit};
                end
            end
            COOK: begin
                if (bus.clear) begin
                    time_nxt  = ZERO_TIME;
                    state_nxt = IDLE;
                end else if (bus.stop || !bus.door_closed) begin
                    presc_nxt = '0;
                    state_nxt = PAUSE;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    time_nxt  = time_dec;
                    if (time_dec == ZERO_TIME) begin
                        beep_nxt  = BEEP_LOAD;
                        state_nxt = DONE;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            PAUSE: begin
                if (bus.clear || bus.stop) begin
                    time_nxt  = ZERO_TIME;
                    state_nxt = IDLE;
                end else if (bus.start && bus.door_closed) begin
                    presc_nxt = '0;
                    state_nxt = COOK;
                end
            end
            DONE: begin
                time_nxt = ZERO_TIME;
                if (bus.clear || bus.stop || !bus.door_closed || beep_cnt == '0) begin
                    beep_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    beep_nxt = beep_cnt - 1'b1;
                end
            end
            default: begin
                time_nxt  = ZERO_TIME;
                presc_nxt = '0;
                beep_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Door opening must kill the magnetron without waiting for a clock edge.
    assign bus.magnetron_en = (state == COOK) && bus.door_closed;
    assign bus.busy         = (state == COOK) || (state == PAUSE);
    assign bus.done_beep    = (state == DONE);
    assign bus.time_bcd     = time_q;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer: reference model in seconds/decimal
// arithmetic pushes expected outputs, a negedge monitor pops and compares.
module tb_cook_sequencer;

    localparam int TPS  = 4;
    localparam int BEEP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cook_sequencer_if bus ();

    cook_sequencer #(.TICKS_PER_SEC(TPS), .BEEP_CYCLES(BEEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        mag;
        logic [15:0] tm;
        logic        busy;
        logic        beep;
        logic [2:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic door   = 1'b1;
    logic armed  = 1'b0;

    // Reference model: ms = state number, val = entered decimal number,
    // secs = remaining seconds, pc = cycles since COOK entry, bc = beep cycles left.
    int ms = 0, val = 0, secs = 0, pc = 0, bc = 0;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t model_out(logic dr);
        exp_t e;
        e.st   = 3'(ms);
        e.mag  = (ms == 2) && dr;
        e.busy = (ms == 2) || (ms == 3);
        e.beep = (ms == 4);
        if (ms == 0)      e.tm = 16'h0000;
        else if (ms == 1) e.tm = to_bcd(val);
        else              e.tm = to_bcd((secs / 60) * 100 + secs % 60);
        return e;
    endfunction

    task automatic model_edge(input logic r, st, sp, cl, dr, dv, input logic [3:0] d);
        if (r) begin
            ms = 0; val = 0; secs = 0; pc = 0; bc = 0;
            return;
        end
        case (ms)
            0: if (!(cl || sp) && dv && d <= 9) begin val = int'(d); ms = 1; end
            1: begin
                if (cl || sp) begin
                    val = 0; ms = 0;
                end else if (st && dr && val != 0) begin
                    int mm, ss;
                    mm = val / 100; ss = val % 100;
                    if (ss > 59) begin ss -= 60; mm++; end
                    if (mm > 99) begin mm = 99; ss = 59; end
                    secs = mm * 60 + ss; val = 0; pc = 0; ms = 2;
                end else if (dv && d <= 9 && val < 1000) begin
                    val = val * 10 + int'(d);
                end
            end
            2: begin
                if (cl) begin ms = 0; secs = 0; end
                else if (sp || !dr) ms = 3;
                else begin
                    pc++;
                    if (pc == TPS) begin
                        pc = 0; secs--;
                        if (secs == 0) begin ms = 4; bc = BEEP; end
                    end
                end
            end
            3: begin
                if (cl || sp) begin ms = 0; secs = 0; end
                else if (st && dr) begin ms = 2; pc = 0; end
            end
            4: begin
                if (cl || sp || !dr) ms = 0;
                else begin bc--; if (bc == 0) ms = 0; end
            end
            default: ms = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, want);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, apply the edge to the model.
    task automatic cyc(input logic r, st, sp, cl, dv, input logic [3:0] d);
        rst             = r;
        bus.start       = st;
        bus.stop        = sp;
        bus.clear       = cl;
        bus.door_closed = door;
        bus.digit_valid = dv;
        bus.digit       = d;
        if (armed) exp_q.push_back(model_out(door));
        @(posedge clk);
        model_edge(r, st, sp, cl, door, dv, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic key(input logic [3:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic press_start();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic press_stop();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic press_clear();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    // Monitor: every cycle the DUT presents its outputs, check them against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("magnetron_en", 16'(bus.magnetron_en), 16'(e.mag));
            chk("time_bcd",     bus.time_bcd,          e.tm);
            chk("busy",         16'(bus.busy),         16'(e.busy));
            chk("done_beep",    16'(bus.done_beep),    16'(e.beep));
            chk("state_o",      16'(bus.state_o),      16'(e.st));
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        armed = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset_time", bus.time_bcd, 16'h0000);
        chk("reset_state", 16'(bus.state_o), 16'd0);

        // 01:05 full cook to completion
        key(4'd1); key(4'd0); key(4'd5);
        press_start();
        chk("s1_entry_time", bus.time_bcd, 16'h0105);
        chk("s1_mag_on", 16'(bus.magnetron_en), 16'd1);
        idle(4);
        chk("s1_first_dec", bus.time_bcd, 16'h0104);
        idle(256);
        chk("s1_done_state", 16'(bus.state_o), 16'd4);
        chk("s1_done_beep", 16'(bus.done_beep), 16'd1);
        idle(3);
        chk("s1_back_idle", 16'(bus.state_o), 16'd0);

        // normalization and saturation
        key(4'd0); key(4'd0); key(4'd9); key(4'd9);
        press_start();
        chk("s2_norm_0139", bus.time_bcd, 16'h0139);
        press_clear();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        press_start();
        chk("s2_sat_9959", bus.time_bcd, 16'h9959);
        press_clear();

        // 4-digit limit, invalid digit
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'hA);
        chk("s3_limit", bus.time_bcd, 16'h1234);
        press_clear();

        // door interlock and resume
        key(4'd3); key(4'd0);
        press_start();
        door = 1'b0;
        idle(1);
        chk("s4_pause", 16'(bus.state_o), 16'd3);
        idle(20);
        chk("s4_held", bus.time_bcd, 16'h0030);
        door = 1'b1;
        press_start();
        idle(3);
        chk("s4_no_early_dec", bus.time_bcd, 16'h0030);
        idle(1);
        chk("s4_dec", bus.time_bcd, 16'h0029);

        // stop pause / cancel, stop mid-beep
        press_stop();
        chk("s5_pause", 16'(bus.state_o), 16'd3);
        press_stop();
        chk("s5_cancel_time", bus.time_bcd, 16'h0000);
        key(4'd1);
        press_start();
        idle(5);
        chk("s5_in_done", 16'(bus.done_beep), 16'd1);
        press_stop();
        chk("s5_beep_off", 16'(bus.done_beep), 16'd0);

        // reset mid-cook with start held, start ignored cases
        key(4'd5);
        press_start();
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("s6_rst_state", 16'(bus.state_o), 16'd0);
        chk("s6_rst_mag", 16'(bus.magnetron_en), 16'd0);
        door = 1'b0;
        key(4'd2);
        press_start();
        chk("s6_door_open", 16'(bus.state_o), 16'd1);
        door = 1'b1;
        press_clear();
        key(4'd0);
        press_start();
        chk("s6_zero_time", 16'(bus.state_o), 16'd1);
        press_clear();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, st, sp, cl, dv;
            logic [3:0] d;
            if ($urandom_range(0, 29) == 0) door = ~door;
            r  = ($urandom_range(0, 399) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 49) == 0);
            dv = ($urandom_range(0, 2) == 0);
            d  = 4'($urandom_range(0, 11));
            cyc(r, st, sp, cl, dv, d);
        end
        idle(2);
        @(negedge clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
